// File: rtl/src_pingpong_buf.sv
// Ring of NBANK word-addressed banks: a producer fills one bank while a consumer reads a filled one.
// Read latency is one cycle; src_ready drops when every bank is full, and reads with nothing filled are flagged.
module src_pingpong_buf #(
    parameter int DW    = 32,
    parameter int WPW   = 2,
    parameter int DEPTH = 1024,
    parameter int NBANK = 2,
    localparam int AW   = $clog2(DEPTH),
    localparam int BW   = (NBANK > 2) ? $clog2(NBANK) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              src_v,
    input  logic [AW-1:0]     src_a,
    input  logic [DW*WPW-1:0] src_d,
    input  logic              src_last,
    output logic              src_ready,
    input  logic              exec,
    input  logic [AW-1:0]     exec_src_addr,
    input  logic              exec_done,
    output logic [DW-1:0]     exec_src_data,
    output logic              exec_src_v,
    output logic              rd_avail,
    output logic [BW-1:0]     wr_bank,
    output logic [BW-1:0]     rd_bank,
    output logic [BW:0]       full_cnt,
    output logic              err_wr,
    output logic              err_rd
);

    logic [DW-1:0] mem [NBANK*DEPTH];
    logic [AW-1:0] lane_a [WPW];
    logic          wr_acc;
    logic          rd_acc;
    logic          commit;
    logic          release_bank;

    assign src_ready    = (full_cnt < (BW+1)'(NBANK));
    assign rd_avail     = (full_cnt != '0);
    assign wr_acc       = src_v & src_ready;
    assign rd_acc       = exec & rd_avail;
    assign commit       = wr_acc & src_last;
    assign release_bank = exec_done & rd_avail;

    // Lane addresses wrap within the bank rather than spilling into the next one.
    always_comb begin
        for (int i = 0; i < WPW; i++) begin
            lane_a[i] = src_a + AW'(i);
        end
    end

    // Storage has no reset; the explicit rst gate keeps a reset edge from writing.
    always_ff @(posedge clk) begin
        if (!rst && wr_acc) begin
            for (int i = 0; i < WPW; i++) begin
                mem[{wr_bank, lane_a[i]}] <= src_d[DW*i +: DW];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_bank       <= '0;
            rd_bank       <= '0;
            full_cnt      <= '0;
            exec_src_data <= '0;
            exec_src_v    <= 1'b0;
            err_wr        <= 1'b0;
            err_rd        <= 1'b0;
        end else begin
            exec_src_v <= rd_acc;
            // Reads use the pre-advance rd_bank, so read+release in one cycle hits the old bank.
            if (rd_acc) begin
                exec_src_data <= mem[{rd_bank, exec_src_addr}];
            end
            if (commit) begin
                wr_bank <= wr_bank + BW'(1);
            end
            if (release_bank) begin
                rd_bank <= rd_bank + BW'(1);
            end
            case ({commit, release_bank})
                2'b10:   full_cnt <= full_cnt + (BW+1)'(1);
                2'b01:   full_cnt <= full_cnt - (BW+1)'(1);
                default: full_cnt <= full_cnt;
            endcase
            if (src_v && !src_ready) begin
                err_wr <= 1'b1;
            end
            if ((exec || exec_done) && !rd_avail) begin
                err_rd <= 1'b1;
            end
        end
    end

endmodule
